// File: rtl/lfsr_pkg.sv
// Shared constants and types for the PRBS generator/checker pair.
package lfsr_pkg;
  localparam int         LFSR_N         = 8;
  localparam logic [7:0] LFSR_TAPS      = 8'hB8;  // x^8+x^6+x^5+x^4+1
  localparam int         LOCK_GOOD_DEF  = 16;
  localparam int         LOCK_BAD_DEF   = 4;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } lfsr_state_e;
endpackage

// File: rtl/lfsr_step.sv
// One LFSR step: the predicted next bit and the shifted state.
// Shared by the generator and the checker.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int             N    = LFSR_N,
  parameter logic [N-1:0]   TAPS = LFSR_TAPS
) (
  input  logic [N-1:0] i_lfsr,
  input  logic         i_in_bit,
  output logic         o_pred,
  output logic [N-1:0] o_next
);
  assign o_pred = ^(i_lfsr & TAPS);
  assign o_next = {i_lfsr[N-2:0], i_in_bit};
endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising serial PRBS checker.
// FILL loads N received bits, SEARCH counts consecutive correct predictions
// until lock, LOCKED free-runs the local LFSR and flags mismatched bits.
// Optional error counter: define LFSR_CHECKER_ERR_COUNT_EN to build it,
// otherwise o_err_cnt is tied to zero.
// The local LFSR is not cleared by i_resync; the refill overwrites it anyway.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int           N         = LFSR_N,
  parameter logic [N-1:0] TAPS      = LFSR_TAPS,
  parameter int           LOCK_GOOD = LOCK_GOOD_DEF,
  parameter int           LOCK_BAD  = LOCK_BAD_DEF,
  parameter int           CNT_W     = 16
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_data,
  input  logic             i_resync,
  output logic             o_lock,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_cnt
);
  localparam int FILL_W = $clog2(N + 1);
  localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
  localparam int BAD_W  = $clog2(LOCK_BAD + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_GOOD - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(LOCK_BAD - 1);

  lfsr_state_e        r_state;
  logic [N-1:0]       r_lfsr;
  logic [FILL_W-1:0]  r_fill_cnt;
  logic [GOOD_W-1:0]  r_good_cnt;
  logic [BAD_W-1:0]   r_bad_cnt;
  logic               r_lock;
  logic               r_err;

  logic         w_pred;
  logic [N-1:0] w_next;
  logic         w_in_bit;
  logic         w_match;
  logic         w_step;
  logic         w_lock_evt;
  logic         w_err_evt;

  // Once locked the local LFSR feeds itself, so line errors cannot corrupt it
  assign w_in_bit   = (r_state == ST_LOCKED) ? w_pred : i_data;
  assign w_match    = (i_data == w_pred);
  assign w_step     = i_valid && !i_resync;
  assign w_lock_evt = w_step && (r_state == ST_SEARCH) && w_match &&
                      (r_lfsr != '0) && (r_good_cnt == GOOD_LAST);
  assign w_err_evt  = w_step && (r_state == ST_LOCKED) && !w_match;

  lfsr_step #(.N(N), .TAPS(TAPS)) u_step (
    .i_lfsr   (r_lfsr),
    .i_in_bit (w_in_bit),
    .o_pred   (w_pred),
    .o_next   (w_next)
  );

  // Lock FSM, run-length counters and registered lock/error outputs
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_FILL;
      r_lfsr     <= '0;
      r_fill_cnt <= '0;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
      r_lock     <= 1'b0;
      r_err      <= 1'b0;
    end else if (i_resync) begin
      r_state    <= ST_FILL;
      r_fill_cnt <= '0;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
      r_lock     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_err_evt;
      if (i_valid) begin
        r_lfsr <= w_next;
        case (r_state)
          ST_FILL: begin
            if (r_fill_cnt == FILL_LAST) begin
              r_state    <= ST_SEARCH;
              r_fill_cnt <= '0;
            end else begin
              r_fill_cnt <= r_fill_cnt + 1'b1;
            end
          end
          ST_SEARCH: begin
            if (w_lock_evt) begin
              r_state    <= ST_LOCKED;
              r_good_cnt <= '0;
              r_bad_cnt  <= '0;
              r_lock     <= 1'b1;
            end else if (w_match && (r_lfsr != '0)) begin
              r_good_cnt <= r_good_cnt + 1'b1;
            end else begin
              r_good_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            if (w_err_evt) begin
              if (r_bad_cnt == BAD_LAST) begin
                r_state    <= ST_FILL;
                r_bad_cnt  <= '0;
                r_fill_cnt <= '0;
                r_lock     <= 1'b0;
              end else begin
                r_bad_cnt <= r_bad_cnt + 1'b1;
              end
            end else begin
              r_bad_cnt <= '0;
            end
          end
          default: r_state <= ST_FILL;
        endcase
      end
    end
  end

  assign o_lock = r_lock;
  assign o_err  = r_err;

`ifdef LFSR_CHECKER_ERR_COUNT_EN
  logic [CNT_W-1:0] r_err_cnt;

  // Saturating error count, restarted on every lock acquisition
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_cnt <= '0;
    end else if (w_lock_evt) begin
      r_err_cnt <= '0;
    end else if (w_err_evt && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign o_err_cnt = r_err_cnt;
`else
  assign o_err_cnt = '0;
`endif
endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: table of per-bit records plus
// hand-written reset-mid-lock and all-zero sequences.
`timescale 1ns/1ps
module tb_lfsr_checker;
`ifdef LFSR_CHECKER_ERR_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef enum logic [2:0] {K_GEN, K_INV, K_IDLE, K_RESYNC, K_ZERO} kind_e;
  typedef struct {
    kind_e       kind;
    logic        lock;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, data, resync;
  logic        lock, err;
  logic [15:0] err_cnt;

  logic [7:0]  g = 8'h05;   // reference generator state
  int          n_vec = 0;
  int          n_bad = 0;
  vec_t        tbl[$];

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk       (clk),
    .i_rst_n   (rst_n),
    .i_valid   (valid),
    .i_data    (data),
    .i_resync  (resync),
    .o_lock    (lock),
    .o_err     (err),
    .o_err_cnt (err_cnt)
  );

  function automatic logic gen_bit(input logic [7:0] s);
    return ^(s & 8'hB8);
  endfunction

  function automatic void add(input kind_e k, input logic l, input logic e, input logic [15:0] c);
    vec_t v;
    v.kind = k; v.lock = l; v.err = e; v.cnt = c;
    tbl.push_back(v);
  endfunction

  // Drive one cycle of stimulus, then sample 1ns after the edge
  task automatic apply(input kind_e k);
    logic b;
    b = gen_bit(g);
    valid = 1'b0; data = 1'b0; resync = 1'b0;
    case (k)
      K_GEN:    begin valid = 1'b1; data = b;  g = {g[6:0], b}; end
      K_INV:    begin valid = 1'b1; data = ~b; g = {g[6:0], b}; end
      K_RESYNC: resync = 1'b1;
      K_ZERO:   valid = 1'b1;
      default:  ;
    endcase
    @(posedge clk);
    #1;
    valid = 1'b0; data = 1'b0; resync = 1'b0;
  endtask

  task automatic check(input string name, input int idx, input logic l, input logic e, input logic [15:0] c);
    logic [15:0] ec;
    ec = CNT_ON ? c : 16'd0;
    n_vec++;
    if (lock !== l || err !== e || err_cnt !== ec) begin
      n_bad++;
      $display("FAIL %s #%0d: got lock=%b err=%b cnt=%0d, want lock=%b err=%b cnt=%0d",
               name, idx, lock, err, err_cnt, l, e, ec);
    end
  endtask

  initial begin
    // Lock acquisition from reset: 8 fill + 16 matches
    for (int i = 1; i <= 26; i++) add(K_GEN, i >= 24, 1'b0, 16'd0);
    // Single error keeps lock; bad run counter then restarts
    add(K_INV, 1'b1, 1'b1, 16'd1);
    for (int i = 0; i < 5; i++) add(K_GEN, 1'b1, 1'b0, 16'd1);
    for (int i = 0; i < 3; i++) add(K_INV, 1'b1, 1'b1, 16'(2 + i));
    add(K_GEN, 1'b1, 1'b0, 16'd4);
    add(K_IDLE, 1'b1, 1'b0, 16'd4);
    // Resync mid-lock keeps the error count, relock after 24 bits clears it
    add(K_RESYNC, 1'b0, 1'b0, 16'd4);
    for (int i = 1; i <= 24; i++) add(K_GEN, i == 24, 1'b0, (i == 24) ? 16'd0 : 16'd4);
    // Burst of 6 bad bits: 4 pulses, lock drops on the 4th
    for (int i = 1; i <= 6; i++) add(K_INV, i < 4, i <= 4, (i <= 4) ? 16'(i) : 16'd4);
    // Relock with idle gaps between every valid bit
    add(K_RESYNC, 1'b0, 1'b0, 16'd4);
    for (int i = 1; i <= 24; i++) begin
      add(K_GEN,  i == 24, 1'b0, (i == 24) ? 16'd0 : 16'd4);
      add(K_IDLE, i == 24, 1'b0, (i == 24) ? 16'd0 : 16'd4);
    end
    add(K_GEN, 1'b1, 1'b0, 16'd0);

    rst_n = 1'b0; valid = 1'b0; data = 1'b0; resync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].kind);
      check("table", i, tbl[i].lock, tbl[i].err, tbl[i].cnt);
    end

    // Asynchronous reset while locked with a nonzero error count
    apply(K_INV);
    check("pre_rst_err", 0, 1'b1, 1'b1, 16'd1);
    apply(K_GEN);
    check("pre_rst_ok", 0, 1'b1, 1'b0, 16'd1);
    #2 rst_n = 1'b0;
    #1 check("async_rst", 0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      apply(K_GEN);
      if (i >= 23) check("relock_rst", i, i == 24, 1'b0, 16'd0);
    end

    // All-zero stream must never lock
    apply(K_RESYNC);
    check("zero_resync", 0, 1'b0, 1'b0, 16'd0);
    for (int i = 1; i <= 40; i++) begin
      apply(K_ZERO);
      check("all_zero", i, 1'b0, 1'b0, 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
